// File: rtl/add_tree_feeder_64_if.sv
// Stream-in / frame-out bundle for the 64-lane adder-tree feeder.
// master drives words and consumes frames; slave is the feeder.
interface add_tree_feeder_64_if;
  logic          s_valid;
  logic [15:0]   s_data;
  logic          s_last;
  logic          s_ready;
  logic [1:0]    length_mode;
  logic          out_ready;
  logic          valid_out;
  logic [1023:0] out_flat;
  logic [1:0]    length_mode_out;
  logic [6:0]    out_count;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output length_mode,
    output out_ready,
    input  s_ready,
    input  valid_out,
    input  out_flat,
    input  length_mode_out,
    input  out_count
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  length_mode,
    input  out_ready,
    output s_ready,
    output valid_out,
    output out_flat,
    output length_mode_out,
    output out_count
  );
endinterface

// File: rtl/add_tree_feeder_64.sv
// Collects up to 64 16-bit words into a frame and presents it
// flat to a downstream adder tree, zero-filling unused lanes.
module add_tree_feeder_64 (
  input logic clk,
  input logic rst,
  input logic en,
  add_tree_feeder_64_if.slave io
);

  logic [6:0]        count;
  logic              pending;
  logic [63:0][15:0] lanes;
  logic [1:0]        mode_q;

  logic              accept;
  logic              done;
  logic              slot_free;
  logic              xfer;
  logic              drain;
  logic [63:0][15:0] masked;

  assign io.s_ready = en & ~pending;
  assign accept     = io.s_valid & io.s_ready;
  assign done       = accept &
                      (io.s_last | (count == 7'd63));
  assign slot_free  = ~io.valid_out | io.out_ready;
  assign xfer       = en & pending & slot_free;
  assign drain      = en & io.valid_out & io.out_ready;

  // Stale lanes from a longer earlier frame must not leak out.
  always_comb begin
    masked = '0;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) < count) begin
        masked[i] = lanes[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      pending <= 1'b0;
      lanes   <= '0;
      mode_q  <= '0;
    end else if (xfer) begin
      count   <= '0;
      pending <= 1'b0;
    end else if (accept) begin
      lanes[count[5:0]] <= io.s_data;
      count             <= count + 7'd1;
      if (count == 7'd0) begin
        mode_q <= io.length_mode;
      end
      if (done) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io.valid_out       <= 1'b0;
      io.out_flat        <= '0;
      io.length_mode_out <= '0;
      io.out_count       <= '0;
    end else if (xfer) begin
      io.valid_out       <= 1'b1;
      io.out_flat        <= masked;
      io.length_mode_out <= mode_q;
      io.out_count       <= count;
    end else if (drain) begin
      io.valid_out <= 1'b0;
    end
  end

endmodule
